// File: rtl/pmt_pkg.sv
// pmt_pkg: shared FSM states, mode constants and saturating add for the PMT counter
package pmt_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GATE = 1'b1} state_e;
  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_TRIG = 1'b1;
  // a + b clamped to the all-ones value of a w-bit counter (w <= 64)
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic b, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (a >= m) ? m : a + 64'(b);
  endfunction
endpackage

// File: rtl/pmt_chan.sv
// pmt_chan: one PMT channel - synchroniser, edge detect, window/total counters, activity stretch
//   clk_i, rst_ni     : clock, async active-low reset
//   pmt_i             : raw asynchronous discriminator pulse
//   clear_i/gate_i    : clear window accumulator / accumulate edges this cycle
//   publish_i         : last window cycle, load cnt_o/sat_o with acc + current edge
//   act_o, cnt_o, acnt_o, sat_o : stretched activity, published count, running total, published sat
module pmt_chan
  import pmt_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pmt_i,
  input  logic             clear_i,
  input  logic             gate_i,
  input  logic             publish_i,
  output logic             act_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] acnt_o,
  output logic             sat_o
);
  localparam int SW = $clog2(STRETCH + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, rise_q, sat_q, sat_d, psat_q, ovf;
  logic [CNT_W-1:0]       acc_q, acc_d, acc_inc, cnt_q, tot_q;
  logic [SW-1:0]          str_q, str_d;
  always_comb begin
    acc_inc = CNT_W'(sat_add(64'(acc_q), rise_q, CNT_W));
    ovf     = rise_q & (&acc_q);
    acc_d   = clear_i ? '0 : gate_i ? acc_inc : acc_q;
    sat_d   = clear_i ? 1'b0 : sat_q | (gate_i & ovf);
    str_d   = rise_q ? SW'(STRETCH) : (str_q != '0) ? str_q - SW'(1) : str_q;
  end
  // rise_q is registered so a count lands one clock after the edge is seen
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
      cnt_q  <= '0;
      psat_q <= 1'b0;
      tot_q  <= '0;
      str_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pmt_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      acc_q  <= acc_d;
      sat_q  <= sat_d;
      cnt_q  <= publish_i ? acc_inc : cnt_q;
      psat_q <= publish_i ? (sat_q | ovf) : psat_q;
      tot_q  <= tot_q + CNT_W'(rise_q);
      str_q  <= str_d;
    end
  assign act_o  = |str_q;
  assign cnt_o  = cnt_q;
  assign acnt_o = tot_q;
  assign sat_o  = psat_q;
endmodule

// File: rtl/pmt_gated_counter.sv
// pmt_gated_counter: multi-channel PMT photon counter over programmable exposure windows
//   wHClk_i, wRstN_i        : clock, async active-low reset
//   wPmt_i                  : raw discriminator pulses
//   wExpTime_i, wMode_i     : window length minus one, 0 continuous / 1 triggered
//   wStart_i, wEnable_i     : trigger (triggered mode), master enable
//   wPmt_o                  : stretched activity per channel
//   wPmtCnt_o, wSat_o       : last completed window counts and saturation flags
//   wPmtACnt_o              : free-running wrapping totals
//   wValid_o, wBusy_o       : publish strobe, window open
module pmt_gated_counter
  import pmt_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int TIME_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 8
) (
  input  logic                      wHClk_i,
  input  logic                      wRstN_i,
  input  logic [CHANNELS-1:0]       wPmt_i,
  input  logic [TIME_W-1:0]         wExpTime_i,
  input  logic                      wMode_i,
  input  logic                      wStart_i,
  input  logic                      wEnable_i,
  output logic [CHANNELS-1:0]       wPmt_o,
  output logic [CHANNELS*CNT_W-1:0] wPmtCnt_o,
  output logic [CHANNELS*CNT_W-1:0] wPmtACnt_o,
  output logic                      wValid_o,
  output logic                      wBusy_o,
  output logic [CHANNELS-1:0]       wSat_o
);
  state_e            state_q;
  logic [TIME_W-1:0] tmr_q, t_q;
  logic              mode_q, valid_q, start_ok, in_gate, last, clear, gate;
  assign start_ok = wEnable_i & ((wMode_i == MODE_CONT) | wStart_i);
  assign in_gate  = state_q == ST_GATE;
  assign gate     = in_gate & wEnable_i;
  assign last     = gate & (tmr_q == t_q);
  // clear on window entry, abort, and back-to-back restart
  assign clear    = (~in_gate & start_ok) | (in_gate & ~wEnable_i) | (last & (mode_q == MODE_CONT));
  always_ff @(posedge wHClk_i or negedge wRstN_i)
    if (!wRstN_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      t_q     <= '0;
      mode_q  <= MODE_CONT;
      valid_q <= 1'b0;
    end else begin
      valid_q <= last;
      case (state_q)
        ST_IDLE:
          if (start_ok) begin
            state_q <= ST_GATE;
            tmr_q   <= '0;
            t_q     <= wExpTime_i;
            mode_q  <= wMode_i;
          end
        default:
          if (!wEnable_i) state_q <= ST_IDLE;
          else if (tmr_q == t_q) begin
            tmr_q <= '0;
            t_q   <= wExpTime_i;
            if (mode_q == MODE_TRIG) state_q <= ST_IDLE;
          end else tmr_q <= tmr_q + TIME_W'(1);
      endcase
    end
  assign wValid_o = valid_q;
  assign wBusy_o  = in_gate;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pmt_chan #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .STRETCH(STRETCH)) u_chan (
      .clk_i    (wHClk_i),
      .rst_ni   (wRstN_i),
      .pmt_i    (wPmt_i[k]),
      .clear_i  (clear),
      .gate_i   (gate),
      .publish_i(last),
      .act_o    (wPmt_o[k]),
      .cnt_o    (wPmtCnt_o[k*CNT_W +: CNT_W]),
      .acnt_o   (wPmtACnt_o[k*CNT_W +: CNT_W]),
      .sat_o    (wSat_o[k])
    );
  end
endmodule

// File: tb/tb_pmt_gated_counter.sv
// tb_pmt_gated_counter: randomized and directed checks against a behavioural window/edge model
module tb_pmt_gated_counter;
  localparam int CH = 4, CW = 4, TW = 8, S = 2, ST = 8, MAXC = 15;
  logic clk = 1'b0, rst_n, mode, start, en;
  logic [CH-1:0] pmt, act, sat;
  logic [TW-1:0] expt;
  logic [CH*CW-1:0] cnt, acnt;
  logic valid, busy;
  int n_chk = 0, n_fail = 0;
  pmt_gated_counter #(.CHANNELS(CH), .CNT_W(CW), .TIME_W(TW), .SYNC_STAGES(S), .STRETCH(ST)) dut (
    .wHClk_i(clk), .wRstN_i(rst_n), .wPmt_i(pmt), .wExpTime_i(expt), .wMode_i(mode),
    .wStart_i(start), .wEnable_i(en), .wPmt_o(act), .wPmtCnt_o(cnt), .wPmtACnt_o(acnt),
    .wValid_o(valid), .wBusy_o(busy), .wSat_o(sat));
  always #5 clk = ~clk;
  // model: input history, edge events, window bookkeeping in plain integers
  bit xs[CH][S+2];
  int m_tot[CH], m_acc[CH], m_cnt[CH], m_since[CH];
  bit m_sat[CH];
  bit m_open, m_mode, m_valid;
  int m_tmr, m_t;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, got, want);
    end
  endtask
  task automatic m_reset();
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < S + 2; i++) xs[k][i] = 1'b0;
      m_tot[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_since[k] = ST; m_sat[k] = 1'b0;
    end
    m_open = 1'b0; m_mode = 1'b0; m_valid = 1'b0; m_tmr = 0; m_t = 0;
  endtask
  task automatic m_step();
    bit e[CH];
    if (!rst_n) begin
      m_reset();
      return;
    end
    m_valid = 1'b0;
    for (int k = 0; k < CH; k++) begin
      // an input rising edge is counted S+1 clocks after it is first sampled
      e[k] = xs[k][S] && !xs[k][S+1];
      for (int i = S + 1; i > 0; i--) xs[k][i] = xs[k][i-1];
      xs[k][0] = pmt[k];
      m_tot[k] = (m_tot[k] + int'(e[k])) % (MAXC + 1);
      m_since[k] = e[k] ? 0 : (m_since[k] < ST) ? m_since[k] + 1 : m_since[k];
    end
    if (!m_open) begin
      if (en && (!mode || start)) begin
        m_open = 1'b1; m_tmr = 0; m_t = int'(expt); m_mode = mode;
        for (int k = 0; k < CH; k++) m_acc[k] = 0;
      end
    end else if (!en) begin
      m_open = 1'b0;
      for (int k = 0; k < CH; k++) m_acc[k] = 0;
    end else begin
      for (int k = 0; k < CH; k++) m_acc[k] += int'(e[k]);
      if (m_tmr == m_t) begin
        m_valid = 1'b1;
        for (int k = 0; k < CH; k++) begin
          m_cnt[k] = (m_acc[k] > MAXC) ? MAXC : m_acc[k];
          m_sat[k] = m_acc[k] > MAXC;
        end
        if (!m_mode) begin
          m_tmr = 0; m_t = int'(expt);
          for (int k = 0; k < CH; k++) m_acc[k] = 0;
        end else m_open = 1'b0;
      end else m_tmr++;
    end
  endtask
  task automatic compare();
    logic [CH*CW-1:0] ec, ea;
    logic [CH-1:0] es, ex;
    for (int k = 0; k < CH; k++) begin
      ec[k*CW +: CW] = CW'(m_cnt[k]);
      ea[k*CW +: CW] = CW'(m_tot[k]);
      es[k] = m_sat[k];
      ex[k] = m_since[k] < ST;
    end
    check("valid", 64'(valid), 64'(m_valid));
    check("busy", 64'(busy), 64'(m_open));
    check("cnt", 64'(cnt), 64'(ec));
    check("sat", 64'(sat), 64'(es));
    check("acnt", 64'(acnt), 64'(ea));
    check("act", 64'(act), 64'(ex));
  endtask
  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare();
  endtask
  initial begin
    int nv, nb, vidx, hi;
    logic [CH*CW-1:0] held;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; expt = '0; pmt = '0;
    m_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    // continuous: channel k gets k+1 pulses per 100 clocks
    en = 1'b1; expt = 8'd99; nv = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < CH; k++) pmt[k] = (c % 20 == 3) && ((c % 100) / 20 <= k);
      tick();
      if (valid) begin
        nv++;
        if (nv > 1) check("cont_cnt", 64'(cnt), 64'h4321);
      end
    end
    check("cont_windows", 64'(nv), 64'd3);
    // boundary edges: 11-cycle windows with an edge every 2 clocks
    expt = 8'd10;
    for (int c = 0; c < 88; c++) begin
      pmt = (c % 2 == 0) ? 4'hF : 4'h0;
      tick();
    end
    pmt = '0;
    en = 1'b0;
    tick();
    // triggered single window with a second, ignored trigger
    en = 1'b1; mode = 1'b1; expt = 8'd9;
    repeat (3) tick();
    start = 1'b1; nb = 0; vidx = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      start = (i == 4);
      if (busy) nb++;
      if (valid) vidx = i;
    end
    start = 1'b0;
    check("trig_busy", 64'(nb), 64'd10);
    check("trig_vidx", 64'(vidx), 64'd10);
    // saturation: 20 pulses in one window from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; expt = 8'd60; start = 1'b1;
    tick();
    start = 1'b0; nv = 0;
    for (int i = 0; i < 65; i++) begin
      pmt[0] = (i < 40) && (i % 2 == 0);
      tick();
      if (valid) begin
        nv++;
        check("sat_cnt", 64'(cnt[CW-1:0]), 64'd15);
        check("sat_flag", 64'(sat[0]), 64'd1);
      end
    end
    check("sat_seen", 64'(nv), 64'd1);
    check("sat_wrap", 64'(acnt[CW-1:0]), 64'd4);
    // abort: enable dropped mid-window holds published counts
    mode = 1'b0; expt = 8'd20;
    for (int i = 0; i < 35; i++) begin
      pmt = 4'($urandom);
      tick();
    end
    held = cnt; en = 1'b0; nv = 0;
    for (int i = 0; i < 30; i++) begin
      pmt = 4'($urandom);
      tick();
      if (valid) nv++;
    end
    check("abort_novalid", 64'(nv), 64'd0);
    check("abort_hold", 64'(cnt), 64'(held));
    // reset mid-window clears outputs immediately
    en = 1'b1; expt = 8'd50;
    for (int i = 0; i < 20; i++) begin
      pmt = 4'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_acnt", 64'(acnt), 64'd0);
    check("rst_act", 64'(act), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    m_reset();
    pmt = '0;
    tick();
    rst_n = 1'b1;
    // activity stretch: single pulse, then two edges 4 clocks apart
    en = 1'b0;
    repeat (10) tick();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      pmt[1] = (i == 0);
      tick();
      hi += int'(act[1]);
    end
    check("stretch_one", 64'(hi), 64'd8);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      pmt[1] = (i == 0) || (i == 4);
      tick();
      hi += int'(act[1]);
    end
    check("stretch_two", 64'(hi), 64'd12);
    // randomized traffic with short windows
    for (int i = 0; i < 3000; i++) begin
      en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      start = $urandom_range(0, 7) == 0;
      expt = 8'($urandom_range(0, 7));
      pmt = 4'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
